// File: rtl/gpr_file.sv
// rtl/gpr_file.sv - parametrised GPR file with write bypass and busy-bit scoreboard
module gpr_file #(
    parameter int ARCH_WIDTH = 64,
    parameter int REG_COUNT  = 32,
    parameter int SEL_WIDTH  = 5,
    parameter int READ_PORTS = 2,
    parameter int ZERO_REG   = 1,
    parameter logic [ARCH_WIDTH-1:0] RESET_VAL = '0,
    localparam int CNT_WIDTH = $clog2(REG_COUNT + 1)
) (
    input  logic                             clk_i,
    input  logic                             rstN_i,
    input  logic [READ_PORTS*SEL_WIDTH-1:0]  rAddr_i,
    output logic [READ_PORTS*ARCH_WIDTH-1:0] rData_o,
    output logic [READ_PORTS-1:0]            rBusy_o,
    input  logic                             wEn_i,
    input  logic [SEL_WIDTH-1:0]             wAddr_i,
    input  logic [ARCH_WIDTH-1:0]            wData_i,
    input  logic                             resvEn_i,
    input  logic [SEL_WIDTH-1:0]             resvAddr_i,
    input  logic                             flush_i,
    output logic [CNT_WIDTH-1:0]             busyCount_o
);

    logic [ARCH_WIDTH-1:0] regs_q [REG_COUNT];
    logic [ARCH_WIDTH-1:0] regs_d [REG_COUNT];
    logic [REG_COUNT-1:0]  busy_q, busy_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [REG_COUNT-1:0]  w_hit, r_hit;
    logic                  w_valid, cnt_set, cnt_clr;

    // One-hot decode; out-of-range and hardwired-zero targets decode to nothing.
    always_comb begin
        w_hit = '0;
        r_hit = '0;
        for (int i = 0; i < REG_COUNT; i++) begin
            w_hit[i] = wEn_i && (wAddr_i == SEL_WIDTH'(i)) && !(ZERO_REG != 0 && i == 0);
            r_hit[i] = resvEn_i && (resvAddr_i == SEL_WIDTH'(i)) && !(ZERO_REG != 0 && i == 0);
        end
        w_valid = |w_hit;
    end

    always_comb begin
        regs_d = regs_q;
        for (int i = 0; i < REG_COUNT; i++) begin
            if (w_hit[i]) begin
                regs_d[i] = wData_i;
            end
        end
        // Reservation is applied last so it beats both the write clear and the flush.
        busy_d  = flush_i ? '0 : busy_q;
        busy_d  = (busy_d & ~w_hit) | r_hit;
        cnt_set = |(r_hit & ~busy_q);
        cnt_clr = |(w_hit & busy_q & ~r_hit);
        if (flush_i) begin
            cnt_d = CNT_WIDTH'(w_valid & 1'b0) + CNT_WIDTH'(|r_hit);
        end else begin
            cnt_d = cnt_q + CNT_WIDTH'(cnt_set) - CNT_WIDTH'(cnt_clr);
        end
    end

    always_comb begin
        rData_o = '0;
        rBusy_o = '0;
        for (int k = 0; k < READ_PORTS; k++) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                if (rAddr_i[k*SEL_WIDTH +: SEL_WIDTH] == SEL_WIDTH'(i) && !(ZERO_REG != 0 && i == 0)) begin
                    rData_o[k*ARCH_WIDTH +: ARCH_WIDTH] = regs_q[i];
                    rBusy_o[k]                          = busy_q[i];
                end
            end
            if (w_valid && wAddr_i == rAddr_i[k*SEL_WIDTH +: SEL_WIDTH]) begin
                rData_o[k*ARCH_WIDTH +: ARCH_WIDTH] = wData_i;
                rBusy_o[k]                          = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rstN_i) begin
        if (!rstN_i) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                regs_q[i] <= RESET_VAL;
            end
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    assign busyCount_o = cnt_q;

endmodule
